// File: rtl/alu_issue_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_if
//  Description : Instruction valid/ready handshake between decoder and issue
//  Revision    : 1.0
// ============================================================================
interface alu_issue_if #(
    parameter int IMM_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [3:0]       in_rd;
    logic [3:0]       in_rs1;
    logic [3:0]       in_rs2;
    logic             in_use_imm;
    logic [IMM_W-1:0] in_imm;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue
//  Description : Issue/writeback stage around a registered 64-bit ALU; owns
//                the 16-entry register file and the zero flag.
//  Revision    : 1.0
// ============================================================================
module alu_issue #(
    parameter int ALU_W = 64,
    parameter int IMM_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    alu_issue_if.slave            in_if,
    output logic [3:0]            alu_ctl,
    output logic [ALU_W-1:0]      alu_a,
    output logic [ALU_W-1:0]      alu_b,
    input  wire logic [ALU_W-1:0] alu_out,
    input  wire logic             alu_zero,
    output logic                  done,
    output logic                  err,
    output logic                  flag_z,
    input  wire logic [3:0]       dbg_addr,
    output logic [ALU_W-1:0]      dbg_data
);
    localparam logic [3:0] c_OP_NOP = 4'd0;
    localparam logic [3:0] c_OP_DIV = 4'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WB    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       ctl_q, ctl_d;
    logic             ill_q, ill_d;
    logic [3:0]       rd_q, rd_d;
    logic [ALU_W-1:0] a_q, a_d;
    logic [ALU_W-1:0] b_q, b_d;
    logic             flag_z_q, flag_z_d;
    logic [ALU_W-1:0] rf_q [16];
    logic [ALU_W-1:0] rf_d [16];

    logic             w_div_zero;
    logic [ALU_W-1:0] w_wb_result;

    // Divide-by-zero result is defined here, not by the ALU.
    assign w_div_zero  = (ctl_q == c_OP_DIV) && (b_q == '0);
    assign w_wb_result = w_div_zero ? {ALU_W{1'b1}} : alu_out;

    always_comb begin
        state_d  = state_q;
        ctl_d    = ctl_q;
        ill_d    = ill_q;
        rd_d     = rd_q;
        a_d      = a_q;
        b_d      = b_q;
        flag_z_d = flag_z_q;
        rf_d     = rf_q;
        case (state_q)
            S_IDLE: begin
                if (in_if.in_valid) begin
                    // Illegal ops travel through the ALU as a NOP.
                    ctl_d   = in_if.in_op[3] ? c_OP_NOP : in_if.in_op;
                    ill_d   = in_if.in_op[3];
                    rd_d    = in_if.in_rd;
                    a_d     = rf_q[in_if.in_rs1];
                    b_d     = in_if.in_use_imm ? {{(ALU_W-IMM_W){1'b0}}, in_if.in_imm}
                                               : rf_q[in_if.in_rs2];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WB;
            S_WB: begin
                if (ctl_q != c_OP_NOP) begin
                    if (rd_q != 4'd0) begin
                        rf_d[rd_q] = w_wb_result;
                    end
                    flag_z_d = !w_div_zero && alu_zero;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ctl_q    <= '0;
            ill_q    <= 1'b0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            flag_z_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ctl_q    <= ctl_d;
            ill_q    <= ill_d;
            rd_q     <= rd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            flag_z_q <= flag_z_d;
            rf_q     <= rf_d;
        end
    end

    // r0 is never written, so its entry stays at the reset value of zero.
    assign in_if.in_ready = (state_q == S_IDLE);
    assign alu_ctl        = ctl_q;
    assign alu_a          = a_q;
    assign alu_b          = b_q;
    assign done           = (state_q == S_WB);
    assign err            = (state_q == S_WB) && ill_q;
    assign flag_z         = flag_z_q;
    assign dbg_data       = rf_q[dbg_addr];
endmodule
`default_nettype wire

// File: doc/alu_issue.md
# alu_issue

Issue and writeback stage wrapped around the 64-bit registered ALU. Accepts one instruction at a time over a valid/ready handshake, reads operands from a 16 x 64-bit register file, and drives `ctl`/`a`/`b` into the ALU. It captures the ALU's registered result one cycle later and writes it back to the destination register, updating a zero flag. Sits between the instruction decoder and the ALU, and owns the architectural register file.

## Interface
- `ALU_W`, 64, datapath and register width
- `IMM_W`, 16, immediate width; zero-extended to `ALU_W`
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `in_valid` input 1: instruction offered
- `in_ready` output 1: stage can accept; high only in IDLE
- `in_op` input 4: 0 = NOP, 1–7 = ALU ctl code, 8–15 = illegal
- `in_rd`, `in_rs1`, `in_rs2` input 4 each: register indices
- `in_use_imm` input 1: B operand = zero-extended `in_imm` instead of `rf[in_rs2]`
- `in_imm` input IMM_W: immediate
- `alu_ctl` output 4: to ALU `ctl`
- `alu_a`, `alu_b` output ALU_W: to ALU `a`, `b`
- `alu_out` input ALU_W: from ALU `out`, registered in the ALU
- `alu_zero` input 1: from ALU `zero`
- `done` output 1: one-cycle pulse when an instruction retires
- `err` output 1: one-cycle pulse with `done` for an illegal op
- `flag_z` output 1: zero flag of the last retired writing instruction
- `dbg_addr` input 4 / `dbg_data` output ALU_W: combinational register-file read port

## Operation
- Register file: 16 x ALU_W. `r0` reads as 0 and writes to it are dropped.
- FSM states: IDLE, ISSUE, WB.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch op, rd, A=`rf[rs1]`, B=(`in_use_imm` ? zext(imm) : `rf[rs2]`) into issue registers; go to ISSUE.
- ISSUE:
  - `alu_ctl`/`alu_a`/`alu_b` are driven from the issue registers; the ALU captures them at the end of this cycle.
  - Next state is WB.
- WB:
  - `alu_out`/`alu_zero` hold the result of the issued op.
  - Writeback result = `alu_out`, except op 6 with B==0, which gives all-ones.
  - If op is 1–7: write the result to `rf[rd]` and set `flag_z` = (result==0); the DIV-by-zero case gives `flag_z`=0.
  - Assert `done`.
  - Next state is IDLE.
- NOP (op 0): traverses ISSUE/WB with `alu_ctl`=0; no write; `flag_z` unchanged; `done`=1.
- Illegal op (8–15): as NOP, plus `err`=1 with `done`.
- In IDLE, `alu_ctl`/`alu_a`/`alu_b` hold the values of the last issue; ALU output is ignored outside WB.
- `in_valid` while not in IDLE is ignored; the upstream must hold the instruction until `in_ready`.
- Operand read happens at accept time. The register file is written at the end of WB, before the next accept is possible, so no hazard logic is needed.

## Timing
- Reset (async assert, synchronous-release usage):
  - state=IDLE, all `rf`=0, `flag_z`=0, `done`=0, `err`=0.
  - `alu_ctl`=0, `alu_a`=0, `alu_b`=0, `in_ready`=1 after reset.
- Accept at edge T0; ISSUE during cycle T0→T1; WB during cycle T1→T2; `done` high in WB cycle.
- Write visible on `dbg_data` and to the next accept from the cycle after WB.
- Throughput: one instruction per 3 cycles; `in_ready` low for exactly 2 cycles after each accept.
- Reset asserted in ISSUE or WB: the instruction is abandoned, there is no write and no `done`, and the stage returns to IDLE immediately.
- Shift amounts and arithmetic: full ALU_W, no truncation in this stage; MUL keeps the low ALU_W bits.

## Test plan
- Reset, then ADD: op1, r1 = r0 + imm 5, then op1, r2 = r1 + imm 7 → `dbg_data`(r2)=12, `flag_z`=0, `done` pulses 2 cycles after each accept.
- SUB to zero: r3 = r1 − r1 (`in_use_imm`=0) → r3=0, `flag_z`=1; following NOP leaves `flag_z`=1.
- Handshake: hold `in_valid`=1 continuously with 3 distinct instructions → `in_ready` pattern 1,0,0 repeating, exactly 3 `done` pulses, results in order.
- DIV by zero: r4 = r2 / imm 0 → r4=64'hFFFF_FFFF_FFFF_FFFF, `flag_z`=0; and r5 = imm 100 / imm 7 via r-regs → 14.
- Illegal op 9 and write to r0 (op1, rd=0, imm 3) → `err`+`done` on the first only; r0 reads 0; no register changes.
- Assert `rst_n` low during ISSUE of r6 = r2 SHL imm 4 → no `done`, r6=0, all registers 0, `in_ready`=1 on release.
